// File: rtl/gun_aim_ctrl_if.sv
// ============================================================================
// gun_aim_ctrl_if : joystick/tick inputs and gun-aim outputs of gun_aim_ctrl.
// Optional GUN_AIM_RECENTER_EN adds the recenter strobe.  Rev 1.0
// ============================================================================
`default_nettype none

interface gun_aim_ctrl_if #(
  parameter int POS_W = 6
);
  logic             tick_4ms;
  logic             left;
  logic             right;
  logic             up;
  logic             down;
`ifdef GUN_AIM_RECENTER_EN
  logic             recenter;
`endif
  logic [POS_W-1:0] gun_h;
  logic [POS_W-1:0] gun_v;
  logic             aim_busy;

  modport master (
    output tick_4ms, left, right, up, down,
`ifdef GUN_AIM_RECENTER_EN
    output recenter,
`endif
    input  gun_h, gun_v, aim_busy
  );

  modport slave (
    input  tick_4ms, left, right, up, down,
`ifdef GUN_AIM_RECENTER_EN
    input  recenter,
`endif
    output gun_h, gun_v, aim_busy
  );
endinterface

`default_nettype wire

// File: rtl/gun_aim_ctrl.sv
// ============================================================================
// gun_aim_ctrl : per-axis accelerating light-gun aim sequencer (Turkey Shoot).
// Optional feature macro: GUN_AIM_RECENTER_EN (recenter input).  Rev 1.0
// ============================================================================
`default_nettype none

module gun_aim_ctrl #(
  parameter int POS_W       = 6,
  parameter int POS_MAX     = 63,
  parameter int CENTER      = 32,
  parameter int SLOW_DIV    = 3,
  parameter int FAST_DIV    = 1,
  parameter int ACCEL_TICKS = 24
) (
  input  logic           clock_12,
  input  logic           reset,
  gun_aim_ctrl_if.slave  aim
);

  localparam int DIV_MAX = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
  localparam int DIV_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam int HOLD_W  = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;

  localparam logic [DIV_W-1:0]  C_SLOW_LAST  = DIV_W'(SLOW_DIV - 1);
  localparam logic [DIV_W-1:0]  C_FAST_LAST  = DIV_W'(FAST_DIV - 1);
  localparam logic [HOLD_W-1:0] C_ACCEL_LAST = HOLD_W'(ACCEL_TICKS - 1);
  localparam logic [POS_W-1:0]  C_POS_MAX    = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0]  C_CENTER     = POS_W'(CENTER);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SLOW = 2'd1,
    ST_FAST = 2'd2
  } axis_state_e;

  logic                  tick_r_q;
  logic                  tick_edge_w;
  logic                  recenter_w;
  logic                  aim_busy_q;
  logic [1:0]            inc_w;
  logic [1:0]            dec_w;
  logic [1:0]            busy_d_w;
  logic [1:0][POS_W-1:0] pos_w;

  assign tick_edge_w = aim.tick_4ms & ~tick_r_q;
  // Index 0 is the horizontal axis, index 1 the vertical axis (up decrements).
  assign inc_w = {aim.down, aim.right};
  assign dec_w = {aim.up,   aim.left};

`ifdef GUN_AIM_RECENTER_EN
  assign recenter_w = aim.recenter;
`else
  assign recenter_w = 1'b0;
`endif

  always_ff @(posedge clock_12) begin
    if (reset) begin
      tick_r_q <= 1'b0;
    end else begin
      tick_r_q <= aim.tick_4ms;
    end
  end

  for (genvar a = 0; a < 2; a++) begin : g_axis
    axis_state_e       state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              dir_q, dir_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic              step_w;
    logic              move_w;
    logic              dir_w;

    // Both directions pressed cancels to no movement; dir 1 means increment.
    assign move_w = inc_w[a] ^ dec_w[a];
    assign dir_w  = inc_w[a];

    always_comb begin
      state_d = state_q;
      div_d   = div_q;
      hold_d  = hold_q;
      dir_d   = dir_q;
      step_w  = 1'b0;
      if (tick_edge_w) begin
        if (!move_w) begin
          state_d = ST_IDLE;
          div_d   = '0;
          hold_d  = '0;
        end else if ((state_q == ST_IDLE) || (dir_w != dir_q)) begin
          step_w  = 1'b1;
          state_d = ST_SLOW;
          div_d   = '0;
          hold_d  = '0;
          dir_d   = dir_w;
        end else if (state_q == ST_SLOW) begin
          if (div_q == C_SLOW_LAST) begin
            step_w = 1'b1;
            div_d  = '0;
          end else begin
            div_d = div_q + DIV_W'(1);
          end
          // Promotion resets the divider even if it just counted this tick.
          if (hold_q == C_ACCEL_LAST) begin
            state_d = ST_FAST;
            div_d   = '0;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end else begin
          if (div_q == C_FAST_LAST) begin
            step_w = 1'b1;
            div_d  = '0;
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
      end

      pos_d = pos_q;
      if (step_w) begin
        if (dir_w) begin
          if (pos_q != C_POS_MAX) pos_d = pos_q + POS_W'(1);
        end else begin
          if (pos_q != '0) pos_d = pos_q - POS_W'(1);
        end
      end
    end

    always_ff @(posedge clock_12) begin
      if (reset || recenter_w) begin
        state_q <= ST_IDLE;
        div_q   <= '0;
        hold_q  <= '0;
        dir_q   <= 1'b0;
        pos_q   <= C_CENTER;
      end else begin
        state_q <= state_d;
        div_q   <= div_d;
        hold_q  <= hold_d;
        dir_q   <= dir_d;
        pos_q   <= pos_d;
      end
    end

    assign pos_w[a]    = pos_q;
    assign busy_d_w[a] = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock_12) begin
    if (reset || recenter_w) begin
      aim_busy_q <= 1'b0;
    end else begin
      aim_busy_q <= |busy_d_w;
    end
  end

  assign aim.gun_h    = pos_w[0];
  assign aim.gun_v    = pos_w[1];
  assign aim.aim_busy = aim_busy_q;

endmodule

`default_nettype wire

// File: tb/tb_gun_aim_ctrl.sv
// ============================================================================
// tb_gun_aim_ctrl : randomized self-checking bench for gun_aim_ctrl against a
// run-length reference model.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_gun_aim_ctrl;

  localparam int POS_W    = 6;
  localparam int POS_MAX  = 63;
  localparam int CENTER   = 32;
  localparam int SLOW_DIV = 3;
  localparam int FAST_DIV = 1;
  localparam int ACCEL    = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gun_aim_ctrl_if #(.POS_W(POS_W)) aim ();

  gun_aim_ctrl #(
    .POS_W(POS_W), .POS_MAX(POS_MAX), .CENTER(CENTER),
    .SLOW_DIV(SLOW_DIV), .FAST_DIV(FAST_DIV), .ACCEL_TICKS(ACCEL)
  ) dut (
    .clock_12 (clk),
    .reset    (rst),
    .aim      (aim.slave)
  );

  int errors = 0;
  int checks = 0;

  // Model: per axis, position and length of the current same-direction run.
  int m_pos [2];
  int m_run [2];
  bit m_dir [2];

  function automatic bit step_on(int run);
    if (run <= ACCEL + 1) return ((run - 1) % SLOW_DIV) == 0;
    return ((run - ACCEL - 1) % FAST_DIV) == 0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pos[i] = CENTER;
      m_run[i] = 0;
      m_dir[i] = 1'b0;
    end
  endfunction

  function automatic void model_axis(int a, bit inc, bit dec);
    if (inc == dec) begin
      m_run[a] = 0;
    end else begin
      if (m_run[a] == 0 || m_dir[a] != inc) m_run[a] = 1;
      else m_run[a] = m_run[a] + 1;
      m_dir[a] = inc;
      if (step_on(m_run[a])) begin
        if (inc) m_pos[a] = (m_pos[a] < POS_MAX) ? m_pos[a] + 1 : POS_MAX;
        else     m_pos[a] = (m_pos[a] > 0) ? m_pos[a] - 1 : 0;
      end
    end
  endfunction

  function automatic bit model_busy();
    return (m_run[0] > 0) || (m_run[1] > 0);
  endfunction

  task automatic set_dirs(bit l, bit r, bit u, bit d);
    aim.left  = l;
    aim.right = r;
    aim.up    = u;
    aim.down  = d;
  endtask

  task automatic pulse(int hi);
    @(negedge clk);
    aim.tick_4ms = 1'b1;
    model_axis(0, aim.right, aim.left);
    model_axis(1, aim.down, aim.up);
    repeat (hi) @(negedge clk);
    aim.tick_4ms = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    aim.tick_4ms = 1'b0;
    set_dirs(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    for (int t = 0; t < 10; t++) begin
      pulse(1);
      checks++;
      if (aim.gun_h !== 6'd32) begin
        errors++; $display("FAIL reset_gun_h tick %0d got %0d want 32", t, aim.gun_h);
      end
      checks++;
      if (aim.gun_v !== 6'd32) begin
        errors++; $display("FAIL reset_gun_v tick %0d got %0d want 32", t, aim.gun_v);
      end
      checks++;
      if (aim.aim_busy !== 1'b0) begin
        errors++; $display("FAIL reset_busy tick %0d got %b want 0", t, aim.aim_busy);
      end
    end
  endtask

  task automatic test_slow_steps();
    do_reset();
    set_dirs(0, 1, 0, 0);
    for (int t = 1; t <= 10; t++) begin
      pulse(50);
      checks++;
      if (aim.gun_h !== POS_W'(m_pos[0])) begin
        errors++; $display("FAIL slow_gun_h tick %0d got %0d want %0d", t, aim.gun_h, m_pos[0]);
      end
    end
    checks++;
    if (aim.gun_h !== 6'd36) begin
      errors++; $display("FAIL slow_final_h got %0d want 36", aim.gun_h);
    end
    checks++;
    if (aim.gun_v !== 6'd32) begin
      errors++; $display("FAIL slow_final_v got %0d want 32", aim.gun_v);
    end
    checks++;
    if (aim.aim_busy !== 1'b1) begin
      errors++; $display("FAIL slow_busy got %b want 1", aim.aim_busy);
    end
  endtask

  task automatic test_accel_saturate();
    do_reset();
    set_dirs(0, 1, 0, 0);
    for (int t = 1; t <= 40; t++) begin
      pulse(1 + (t % 3));
      checks++;
      if (aim.gun_h !== POS_W'(m_pos[0])) begin
        errors++; $display("FAIL accel_gun_h tick %0d got %0d want %0d", t, aim.gun_h, m_pos[0]);
      end
    end
    checks++;
    if (aim.gun_h !== 6'd56) begin
      errors++; $display("FAIL accel_40_h got %0d want 56", aim.gun_h);
    end
    repeat (4) pulse(1);
    set_dirs(0, 0, 0, 0);
    pulse(1);
    checks++;
    if (aim.gun_h !== 6'd60 || aim.aim_busy !== 1'b0) begin
      errors++; $display("FAIL accel_at60 got h=%0d busy=%b want h=60 busy=0", aim.gun_h, aim.aim_busy);
    end
    set_dirs(0, 1, 0, 0);
    repeat (40) pulse(1);
    checks++;
    if (aim.gun_h !== 6'd63) begin
      errors++; $display("FAIL sat_h got %0d want 63", aim.gun_h);
    end
    set_dirs(0, 0, 0, 1);
    repeat (46) pulse(1);
    checks++;
    if (aim.gun_v !== 6'd62) begin
      errors++; $display("FAIL down_to62 got %0d want 62", aim.gun_v);
    end
    set_dirs(0, 0, 0, 0);
    pulse(1);
    set_dirs(0, 0, 0, 1);
    repeat (10) pulse(1);
    checks++;
    if (aim.gun_v !== 6'd63 || aim.gun_v !== POS_W'(m_pos[1])) begin
      errors++; $display("FAIL sat_v got %0d want 63 (model %0d)", aim.gun_v, m_pos[1]);
    end
  endtask

  task automatic test_reversal();
    int exp_h [9] = '{33, 33, 33, 34, 34, 33, 33, 33, 32};
    do_reset();
    for (int t = 1; t <= 9; t++) begin
      if (t <= 5) set_dirs(0, 1, 0, 0);
      else        set_dirs(1, 0, 0, 0);
      pulse(1);
      checks++;
      if (aim.gun_h !== POS_W'(exp_h[t-1]) || aim.gun_h !== POS_W'(m_pos[0])) begin
        errors++; $display("FAIL reversal tick %0d got %0d want %0d", t, aim.gun_h, exp_h[t-1]);
      end
    end
  endtask

  task automatic test_both_and_reset();
    do_reset();
    set_dirs(1, 1, 1, 0);
    repeat (4) pulse(1);
    checks++;
    if (aim.gun_h !== 6'd32) begin
      errors++; $display("FAIL both_h got %0d want 32", aim.gun_h);
    end
    checks++;
    if (aim.gun_v !== 6'd30) begin
      errors++; $display("FAIL both_v got %0d want 30", aim.gun_v);
    end
    set_dirs(0, 1, 0, 0);
    repeat (30) pulse(1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (aim.gun_h !== 6'd32 || aim.gun_v !== 6'd32 || aim.aim_busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset got h=%0d v=%0d busy=%b want 32 32 0", aim.gun_h, aim.gun_v, aim.aim_busy);
    end
    rst = 1'b0;
    set_dirs(0, 0, 0, 0);
    model_reset();
  endtask

  task automatic test_random();
    bit [3:0] d;
    do_reset();
    d = 4'($urandom);
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 15) == 0) d = 4'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end
      set_dirs(d[0], d[1], d[2], d[3]);
      pulse($urandom_range(1, 3));
      checks++;
      if (aim.gun_h !== POS_W'(m_pos[0])) begin
        errors++; $display("FAIL rand_gun_h iter %0d got %0d want %0d", t, aim.gun_h, m_pos[0]);
      end
      checks++;
      if (aim.gun_v !== POS_W'(m_pos[1])) begin
        errors++; $display("FAIL rand_gun_v iter %0d got %0d want %0d", t, aim.gun_v, m_pos[1]);
      end
      checks++;
      if (aim.aim_busy !== model_busy()) begin
        errors++; $display("FAIL rand_busy iter %0d got %b want %b", t, aim.aim_busy, model_busy());
      end
    end
  endtask

`ifdef GUN_AIM_RECENTER_EN
  task automatic test_recenter();
    do_reset();
    set_dirs(0, 1, 0, 0);
    repeat (34) pulse(1);
    checks++;
    if (aim.gun_h !== 6'd50) begin
      errors++; $display("FAIL recenter_pre got %0d want 50", aim.gun_h);
    end
    @(negedge clk);
    aim.tick_4ms = 1'b1;
    aim.recenter = 1'b1;
    model_reset();
    @(negedge clk);
    aim.recenter = 1'b0;
    checks++;
    if (aim.gun_h !== 6'd32 || aim.aim_busy !== 1'b0) begin
      errors++; $display("FAIL recenter got h=%0d busy=%b want 32 0", aim.gun_h, aim.aim_busy);
    end
    repeat (3) @(negedge clk);
    aim.tick_4ms = 1'b0;
    @(negedge clk);
    pulse(1);
    checks++;
    if (aim.gun_h !== 6'd33 || aim.gun_h !== POS_W'(m_pos[0])) begin
      errors++; $display("FAIL recenter_next got %0d want 33", aim.gun_h);
    end
  endtask
`endif

  initial begin
    aim.tick_4ms = 1'b0;
    set_dirs(0, 0, 0, 0);
`ifdef GUN_AIM_RECENTER_EN
    aim.recenter = 1'b0;
`endif
    model_reset();
    test_reset();
    test_slow_steps();
    test_accel_saturate();
    test_reversal();
    test_both_and_reset();
    test_random();
`ifdef GUN_AIM_RECENTER_EN
    test_recenter();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
